// File: rtl/device_event_queue.sv
`default_nettype none
// ============================================================================
// Module      : device_event_queue
// Description : Collects connect/disconnect events from N_DEV device ports and
//               queues each state change in a DEPTH-entry FIFO. The FIFO is
//               drained one entry per cycle into a change/on_off pulse stream.
//               The module also keeps a map of connected devices and counts
//               events rejected while the FIFO is full.
// Revision    : 1.0 - initial release
// ============================================================================
module device_event_queue #(
  parameter int N_DEV = 4,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_DEV-1:0]         dev_evt,
  input  logic [N_DEV-1:0]         dev_on,
  input  logic                     hold,
  output logic                     change,
  output logic                     on_off,
  output logic [N_DEV-1:0]         active_map,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  // Event storage: one bit per entry (the requested device state).
  logic              r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;

  logic              w_pop;
  logic [CW-1:0]     w_free;
  logic [CW-1:0]     w_npush;
  logic [31:0]       w_nrej;
  logic [N_DEV-1:0]  w_push_vec;
  logic [N_DEV-1:0]  w_map_nxt;
  logic [AW-1:0]     w_off [N_DEV];
  logic [31:0]       w_drop_sum;
  logic [7:0]        w_drop_nxt;

  // The slot freed by a same-edge pop is usable by an incoming event.
  assign w_pop  = (fifo_count != '0) && !hold;
  assign w_free = C_DEPTH - fifo_count + CW'(w_pop);

  // Walk the devices lowest index first, accepting real state changes while
  // slots remain and counting the rest as rejected.
  always_comb begin
    w_map_nxt  = active_map;
    w_push_vec = '0;
    w_npush    = '0;
    w_nrej     = '0;
    for (int i = 0; i < N_DEV; i++) begin
      w_off[i] = w_npush[AW-1:0];
      if (dev_evt[i] && (dev_on[i] != active_map[i])) begin
        if (w_npush < w_free) begin
          w_push_vec[i] = 1'b1;
          w_map_nxt[i]  = dev_on[i];
          w_npush       = w_npush + CW'(1);
        end else begin
          w_nrej = w_nrej + 32'd1;
        end
      end
    end
  end

  // Drop counter saturates instead of wrapping.
  assign w_drop_sum = {24'd0, drop_cnt} + w_nrej;
  assign w_drop_nxt = (w_drop_sum > 32'd255) ? 8'hFF : w_drop_sum[7:0];

  // Store accepted events at consecutive slots after the write pointer.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_DEV; i++) begin
      if (w_push_vec[i]) begin
        r_mem[r_wr_ptr + w_off[i]] <= dev_on[i];
      end
    end
  end

  // Pointers, occupancy, device map, output pulse and drop bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      fifo_count <= '0;
      active_map <= '0;
      change     <= 1'b0;
      on_off     <= 1'b0;
      overflow   <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      r_wr_ptr   <= r_wr_ptr + w_npush[AW-1:0];
      r_rd_ptr   <= r_rd_ptr + AW'(w_pop);
      fifo_count <= fifo_count + w_npush - CW'(w_pop);
      active_map <= w_map_nxt;
      change     <= w_pop;
      if (w_pop) begin
        on_off <= r_mem[r_rd_ptr];
      end
      if (w_nrej != 32'd0) begin
        overflow <= 1'b1;
      end
      drop_cnt   <= w_drop_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_device_event_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_device_event_queue
// Description : Scoreboard bench for device_event_queue with a queue-based
//               reference model, directed scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_device_event_queue;

  localparam int N = 4;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] dev_evt = '0;
  logic [N-1:0] dev_on  = '0;
  logic         hold    = 1'b0;
  logic         change;
  logic         on_off;
  logic [N-1:0] active_map;
  logic [3:0]   fifo_count;
  logic         overflow;
  logic [7:0]   drop_cnt;

  device_event_queue #(.N_DEV(N), .DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .dev_evt    (dev_evt),
    .dev_on     (dev_on),
    .hold       (hold),
    .change     (change),
    .on_off     (on_off),
    .active_map (active_map),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit           m_q[$];
  bit           exp_q[$];
  logic [N-1:0] m_map = '0;
  int           m_drop = 0;
  bit           m_ovf = 0;

  // Observed pulse stream
  int           pulses = 0;
  bit           got_q[$];
  bit           mon_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus; the model computes this edge from the rules.
  task automatic step(input logic [N-1:0] e, input logic [N-1:0] o, input logic h);
    bit           pop;
    int           free;
    int           rej;
    logic [N-1:0] nm;
    bit           pushes[$];
    dev_evt = e;
    dev_on  = o;
    hold    = h;
    pop  = (m_q.size() != 0) && !h;
    free = D - m_q.size() + (pop ? 1 : 0);
    nm   = m_map;
    rej  = 0;
    for (int i = 0; i < N; i++) begin
      if (e[i] && (o[i] != m_map[i])) begin
        if (pushes.size() < free) begin
          pushes.push_back(o[i]);
          nm[i] = o[i];
        end else begin
          rej++;
        end
      end
    end
    @(posedge clk);
    #1;
    if (pop) exp_q.push_back(m_q.pop_front());
    foreach (pushes[j]) m_q.push_back(pushes[j]);
    m_map = nm;
    if (rej > 0) m_ovf = 1;
    m_drop = (m_drop + rej > 255) ? 255 : m_drop + rej;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, '0, 1'b0);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    dev_evt = '0;
    dev_on  = '0;
    hold    = 1'b0;
    #2;
    rst = 1'b0;
    m_q.delete();
    exp_q.delete();
    m_map  = '0;
    m_drop = 0;
    m_ovf  = 0;
    #1;
    chk("rst_change",  {31'd0, change}, 32'd0);
    chk("rst_on_off",  {31'd0, on_off}, 32'd0);
    chk("rst_map",     {28'd0, active_map}, 32'd0);
    chk("rst_count",   {28'd0, fifo_count}, 32'd0);
    chk("rst_ovf",     {31'd0, overflow}, 32'd0);
    chk("rst_drop",    {24'd0, drop_cnt}, 32'd0);
    #1;
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Monitor: every pulse must match the head of the expected stream.
  always @(negedge clk) begin
    if (mon_en && rst) begin
      chk("change_vs_model", {31'd0, change}, {31'd0, (exp_q.size() != 0)});
      if (change) begin
        pulses++;
        got_q.push_back(on_off);
        if (exp_q.size() != 0) chk("on_off", {31'd0, on_off}, {31'd0, exp_q.pop_front()});
      end
      chk("fifo_count", {28'd0, fifo_count}, m_q.size());
      chk("active_map", {28'd0, active_map}, {28'd0, m_map});
      chk("overflow",   {31'd0, overflow}, {31'd0, m_ovf});
      chk("drop_cnt",   {24'd0, drop_cnt}, m_drop);
    end
  end

  initial begin
    logic [5:0] seq;
    #12;
    chk("init_change", {31'd0, change}, 32'd0);
    chk("init_count",  {28'd0, fifo_count}, 32'd0);
    chk("init_map",    {28'd0, active_map}, 32'd0);
    @(negedge clk);
    rst    = 1'b1;
    mon_en = 1'b1;

    // Single event latency
    step(4'b0001, 4'b0001, 1'b0);
    chk("single_map",   {28'd0, active_map}, 32'd1);
    chk("single_count", {28'd0, fifo_count}, 32'd1);
    chk("single_nochg", {31'd0, change}, 32'd0);
    step('0, '0, 1'b0);
    chk("single_change", {31'd0, change}, 32'd1);
    chk("single_on_off", {31'd0, on_off}, 32'd1);
    chk("single_count0", {28'd0, fifo_count}, 32'd0);

    // Redundant event is ignored
    step(4'b0001, 4'b0001, 1'b0);
    step('0, '0, 1'b0);
    chk("redund_count", {28'd0, fifo_count}, 32'd0);
    chk("redund_chg",   {31'd0, change}, 32'd0);
    chk("redund_drop",  {24'd0, drop_cnt}, 32'd0);

    // Ordering across two cycles
    pulse_reset();
    got_q.delete();
    pulses = 0;
    step(4'b1111, 4'b1111, 1'b0);
    step(4'b0101, 4'b0000, 1'b0);
    idle(8);
    chk("order_pulses", pulses, 32'd6);
    seq = '0;
    for (int k = 0; k < 6 && k < got_q.size(); k++) seq[5-k] = got_q[k];
    chk("order_seq", {26'd0, seq}, 32'b111100);
    chk("order_map", {28'd0, active_map}, 32'b1010);

    // Overflow while held
    pulse_reset();
    for (int k = 0; k < 8; k++) step(4'(1 << (k % 4)), ~m_map, 1'b1);
    chk("ovf_fill", {28'd0, fifo_count}, 32'd8);
    step(4'b0011, ~m_map, 1'b1);
    chk("ovf_flag",  {31'd0, overflow}, 32'd1);
    chk("ovf_drop",  {24'd0, drop_cnt}, 32'd2);
    chk("ovf_map",   {28'd0, active_map}, 32'd0);
    pulses = 0;
    idle(12);
    chk("ovf_pulses", pulses, 32'd8);

    // Full with simultaneous pop accepts one candidate
    for (int k = 0; k < 8; k++) step(4'(1 << (k % 4)), ~m_map, 1'b1);
    step(4'b0001, ~m_map, 1'b0);
    chk("full_pop_count", {28'd0, fifo_count}, 32'd8);
    chk("full_pop_drop",  {24'd0, drop_cnt}, 32'd2);
    idle(10);

    // Reset with entries queued
    for (int k = 0; k < 5; k++) step(4'(1 << (k % 4)), ~m_map, 1'b1);
    chk("mid_count", {28'd0, fifo_count}, 32'd5);
    pulse_reset();
    pulses = 0;
    idle(8);
    chk("mid_no_pulses", pulses, 32'd0);

    // Random traffic with alternating held and draining phases
    for (int k = 0; k < 2400; k++) begin
      step(4'($urandom), 4'($urandom), ((k / 60) % 2 == 1) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 5) == 0));
    end
    idle(12);
    chk("drain_empty", exp_q.size(), 32'd0);
    chk("drop_sat",    {24'd0, drop_cnt}, 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
